tdc_multi_channel_aggregator: RTL and testbench

Parametrised N-channel successor to the two-channel TDC output control path. Collects timestamp words from NUMBER_CHANNEL TDC channels, holds one pending word per channel, and arbitrates round-robin into the shared FIFO write port, honouring FIFO back-pressure. Drives a one-hot channel strobe toward EventsRate and keeps per-channel overflow (drop) counters for the RegistersManager.

---
 rtl/tdc_multi_channel_aggregator.sv | 154 +++++++++++++++
 tb/tb_tdc_multi_channel_aggregator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_multi_channel_aggregator.sv
// tdc_multi_channel_aggregator
// Collects timestamp words from NUMBER_CHANNEL TDC channels. Each channel has
// one holding register. Held words are written round-robin into a shared FIFO
// write port, and the arbiter respects FIFO back-pressure. Each channel has a
// saturating counter of words dropped because its holding register was full.
// Optional feature: define TDC_AGG_PRIORITY_EN to add the priority_mode input.
// When priority_mode=1, the arbiter uses fixed lowest-index-first priority.
module tdc_multi_channel_aggregator #(
    parameter int NUMBER_CHANNEL   = 4,
    parameter int FIFO_DATA_LENGTH = 68,
    parameter int DROP_CNT_LENGTH  = 16
) (
    input  logic                                      clk,
    input  logic                                      rsnt,
    input  logic [NUMBER_CHANNEL-1:0]                 ch_valid,
    input  logic [NUMBER_CHANNEL*FIFO_DATA_LENGTH-1:0] ch_data,
    input  logic [NUMBER_CHANNEL-1:0]                 enable_channels,
    input  logic                                      flush,
    input  logic                                      clear_drops,
    input  logic                                      fifo_full,
`ifdef TDC_AGG_PRIORITY_EN
    input  logic                                      priority_mode,
`endif
    output logic [FIFO_DATA_LENGTH-1:0]               o_data,
    output logic                                      write,
    output logic [NUMBER_CHANNEL-1:0]                 sel_onehot,
    output logic [NUMBER_CHANNEL-1:0]                 pending,
    output logic [NUMBER_CHANNEL*DROP_CNT_LENGTH-1:0] drop_count
);

    localparam int N     = NUMBER_CHANNEL;
    localparam int W     = FIFO_DATA_LENGTH;
    localparam int D     = DROP_CNT_LENGTH;
    localparam int PTR_W = $clog2(N);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [W-1:0]     hold_q [N];
    logic             write_q;
    logic [W-1:0]     o_data_q;
    logic [N-1:0]     sel_q;
    logic [D-1:0]     drop_q [N];

    logic             run;
    logic             prio_sel;
    logic [PTR_W-1:0] start;
    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [N-1:0]     grant, cap, drop;

`ifdef TDC_AGG_PRIORITY_EN
    assign prio_sel = priority_mode;
`else
    assign prio_sel = 1'b0;
`endif

    assign run   = (state_q == ST_RUN);
    assign start = prio_sel ? '0 : rr_q;

    // Arbiter: pick the first pending channel at or after the search start.
    // Wrap from the last channel back to channel 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant     = '0;
        rr_d      = rr_q;
        if (run && !fifo_full) begin
            for (int k = 0; k < N; k++) begin
                j = int'(start) + k;
                if (j >= N) j = j - N;
                if (!grant_vld && pend_q[j]) begin
                    grant_vld = 1'b1;
                    grant_idx = PTR_W'(j);
                end
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
            if (!prio_sel)
                rr_d = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Per-channel capture/drop decisions and next occupancy.
    // FLUSH clears all occupancy and ignores incoming words.
    always_comb begin
        cap    = '0;
        drop   = '0;
        pend_d = '0;
        for (int i = 0; i < N; i++) begin
            cap[i]  = run && ch_valid[i] && enable_channels[i] && (!pend_q[i] || grant[i]);
            drop[i] = run && ch_valid[i] && enable_channels[i] && pend_q[i] && !grant[i];
            if (!run)        pend_d[i] = 1'b0;
            else if (cap[i]) pend_d[i] = 1'b1;
            else if (grant[i]) pend_d[i] = 1'b0;
            else             pend_d[i] = pend_q[i];
        end
        state_d = (run && flush) ? ST_FLUSH : ST_RUN;
    end

    // Control state, arbiter pointer, occupancy and registered FIFO-side outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rsnt) begin
            state_q  <= ST_RUN;
            rr_q     <= '0;
            pend_q   <= '0;
            write_q  <= 1'b0;
            o_data_q <= '0;
            sel_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            write_q <= grant_vld;
            sel_q   <= grant;
            if (grant_vld) o_data_q <= hold_q[grant_idx];
        end
    end

    // Holding registers: load a word when its channel captures.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; pend_q qualifies every entry, so a stale word is never read.
        for (int i = 0; i < N; i++)
            if (cap[i]) hold_q[i] <= ch_data[i*W +: W];
    end

    // Saturating drop counters. A clear has priority over an increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rsnt || clear_drops)
                drop_q[i] <= '0;
            else if (drop[i] && (drop_q[i] != '1))
                drop_q[i] <= drop_q[i] + 1'b1;
        end
    end

    assign o_data     = o_data_q;
    assign write      = write_q;
    assign sel_onehot = sel_q;
    assign pending    = pend_q;

    for (genvar g = 0; g < N; g++) begin : g_drop_out
        assign drop_count[g*D +: D] = drop_q[g];
    end

endmodule

// File: tb/tb_tdc_multi_channel_aggregator.sv
// Directed testbench for tdc_multi_channel_aggregator.
// Configuration: 4 channels, 68-bit words, 4-bit drop counters.
module tb_tdc_multi_channel_aggregator;

    localparam int N = 4;
    localparam int W = 68;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rsnt;
    logic [N-1:0]   ch_valid;
    logic [N*W-1:0] ch_data;
    logic [N-1:0]   enable_channels;
    logic           flush;
    logic           clear_drops;
    logic           fifo_full;
`ifdef TDC_AGG_PRIORITY_EN
    logic           priority_mode = 1'b0;
`endif
    logic [W-1:0]   o_data;
    logic           write;
    logic [N-1:0]   sel_onehot;
    logic [N-1:0]   pending;
    logic [N*D-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_multi_channel_aggregator #(
        .NUMBER_CHANNEL  (N),
        .FIFO_DATA_LENGTH(W),
        .DROP_CNT_LENGTH (D)
    ) dut (
        .clk            (clk),
        .rsnt           (rsnt),
        .ch_valid       (ch_valid),
        .ch_data        (ch_data),
        .enable_channels(enable_channels),
        .flush          (flush),
        .clear_drops    (clear_drops),
        .fifo_full      (fifo_full),
`ifdef TDC_AGG_PRIORITY_EN
        .priority_mode  (priority_mode),
`endif
        .o_data         (o_data),
        .write          (write),
        .sel_onehot     (sel_onehot),
        .pending        (pending),
        .drop_count     (drop_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [D-1:0] drops(input int ch);
        return drop_count[ch*D +: D];
    endfunction

    task automatic set_word(input int ch, input logic [W-1:0] v);
        ch_data[ch*W +: W] = v;
    endtask

    logic [W-1:0] exp_data [4];
    logic [N-1:0] exp_sel  [4];

    initial begin
        rsnt = 1'b0; ch_valid = '0; ch_data = '0; enable_channels = '1;
        flush = 1'b0; clear_drops = 1'b0; fifo_full = 1'b0;
        step(2);
        rsnt = 1'b1;

        // Reset state
        check("rst_write", write, 0);
        check("rst_odata", o_data, 0);
        check("rst_sel", sel_onehot, 0);
        check("rst_pending", pending, 0);
        check("rst_drops", drop_count, 0);

        // Round-robin burst from pointer 0
        for (int i = 0; i < N; i++) set_word(i, W'(68'hA + i));
        ch_valid = 4'b1111;
        step();
        ch_valid = '0;
        check("rr0_pending", pending, 4'b1111);
        for (int i = 0; i < N; i++) begin
            step();
            check($sformatf("rr0_write%0d", i), write, 1);
            check($sformatf("rr0_data%0d", i), o_data, 68'hA + i);
            check($sformatf("rr0_sel%0d", i), sel_onehot, 4'b0001 << i);
        end
        step();
        check("rr0_idle", write, 0);
        check("rr0_hold_data", o_data, 68'hD);

        // Basic single-word latency: the write occurs two edges after ch_valid.
        set_word(0, 68'h1);
        ch_valid = 4'b0001;
        step();
        ch_valid = '0;
        check("basic_pend", pending, 4'b0001);
        check("basic_nowrite_yet", write, 0);
        step();
        check("basic_write", write, 1);
        check("basic_data", o_data, 68'h1);
        check("basic_sel", sel_onehot, 4'b0001);
        check("basic_pend_clr", pending, 0);

        // Repeat burst; the pointer is now 1.
        for (int i = 0; i < N; i++) set_word(i, W'(68'hA + i));
        ch_valid = 4'b1111;
        step();
        ch_valid = '0;
        exp_data[0] = 68'hB; exp_sel[0] = 4'b0010;
        exp_data[1] = 68'hC; exp_sel[1] = 4'b0100;
        exp_data[2] = 68'hD; exp_sel[2] = 4'b1000;
        exp_data[3] = 68'hA; exp_sel[3] = 4'b0001;
        for (int i = 0; i < N; i++) begin
            step();
            check($sformatf("rr1_data%0d", i), o_data, exp_data[i]);
            check($sformatf("rr1_sel%0d", i), sel_onehot, exp_sel[i]);
        end
        step();

        // Back-pressure and drops on channel 2; the pointer is now 1.
        fifo_full = 1'b1;
        ch_valid  = 4'b0100;
        set_word(2, 68'h21); step();
        set_word(2, 68'h22); step();
        set_word(2, 68'h23); step();
        ch_valid = '0;
        check("bp_pend", pending, 4'b0100);
        check("bp_drops2", drops(2), 2);
        check("bp_nowrite", write, 0);
        step(2);
        check("bp_still_held", pending, 4'b0100);
        fifo_full = 1'b0;
        step();
        check("bp_write", write, 1);
        check("bp_data", o_data, 68'h21);
        check("bp_sel", sel_onehot, 4'b0100);
        step();
        check("bp_single", write, 0);
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;
        check("bp_clear", drops(2), 0);

        // Saturation on channel 1: one capture followed by 20 drops.
        fifo_full = 1'b1;
        ch_valid  = 4'b0010;
        step(21);
        ch_valid = '0;
        check("sat_drops1", drops(1), 15);
        fifo_full = 1'b0;
        step();
        check("sat_drain_sel", sel_onehot, 4'b0010);
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;

        // A disabled channel neither captures nor counts a drop.
        enable_channels = 4'b1110;
        ch_valid = 4'b0001;
        step();
        ch_valid = '0;
        check("en_nocap", pending, 0);
        check("en_nodrop", drops(0), 0);
        step();
        check("en_nowrite", write, 0);
        enable_channels = '1;

        // Flush: held words are discarded and ch_valid is ignored during FLUSH.
        fifo_full = 1'b1;
        ch_valid = 4'b1111;
        step();
        ch_valid = '0;
        check("fl_full", pending, 4'b1111);
        flush = 1'b1;
        step();
        flush = 1'b0;
        ch_valid = 4'b1111;
        step();
        ch_valid = '0;
        check("fl_pend", pending, 0);
        check("fl_drops", drop_count, 0);
        fifo_full = 1'b0;
        step();
        check("fl_nowrite0", write, 0);
        step();
        check("fl_nowrite1", write, 0);

        // Reset mid-operation. The pointer is 2, so the first grant goes to ch2.
        set_word(0, 68'h30); set_word(1, 68'h31); set_word(2, 68'h32);
        ch_valid = 4'b0111;
        step();
        ch_valid = '0;
        step();
        check("mid_write", write, 1);
        check("mid_data", o_data, 68'h32);
        check("mid_pend", pending, 4'b0011);
        rsnt = 1'b0;
        step();
        rsnt = 1'b1;
        check("mid_rst_write", write, 0);
        check("mid_rst_pend", pending, 0);
        check("mid_rst_data", o_data, 0);
        set_word(1, 68'h41); set_word(3, 68'h43);
        ch_valid = 4'b1010;
        step();
        ch_valid = '0;
        step();
        check("mid_ptr0_sel", sel_onehot, 4'b0010);
        check("mid_ptr0_data", o_data, 68'h41);
        step();
        check("mid_next_sel", sel_onehot, 4'b1000);
        step();

        // Grant and capture in the same cycle on ch0: the new word is kept and no drop is counted.
        set_word(0, 68'h50);
        ch_valid = 4'b0001;
        step();
        set_word(0, 68'h51);
        step();
        ch_valid = '0;
        check("sc_data0", o_data, 68'h50);
        check("sc_pend", pending, 4'b0001);
        check("sc_nodrop", drops(0), 0);
        step();
        check("sc_data1", o_data, 68'h51);
        check("sc_pend_clr", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
